// File: rtl/btn_led_pkg.sv
// Shared types for the key/LED controller: LED modes, key polarity and mode sequencing.
package btn_led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_ON   = 2'd1,
    MODE_SLOW = 2'd2,
    MODE_FAST = 2'd3
  } mode_e;

  localparam logic KEY_PRESSED = 1'b0;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_OFF:  return MODE_ON;
      MODE_ON:   return MODE_SLOW;
      MODE_SLOW: return MODE_FAST;
      default:   return MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser and level debouncer for an active-low key, with registered
// single-cycle press/release strobes issued on the cycle the debounced level flips.
module key_debounce
  import btn_led_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 250_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic press_o,
  output logic release_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC);

  logic             sync1_q;
  logic             sync2_q;
  logic             db_q;
  logic [CNT_W-1:0] cnt_q;

  // Sync flops and debounced level reset to "released" so a key held through reset
  // must still complete a full debounce window afterwards.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      db_q      <= 1'b1;
      cnt_q     <= '0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
    end else begin
      sync1_q   <= key_i;
      sync2_q   <= sync1_q;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      if (sync2_q == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
        cnt_q     <= '0;
        db_q      <= sync2_q;
        press_o   <= (sync2_q == KEY_PRESSED);
        release_o <= (sync2_q != KEY_PRESSED);
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/btn_led_ctrl.sv
// Key-stepped LED mode controller: OFF -> ON -> SLOW -> FAST -> OFF on each clean press.
// Define BTN_LED_LONGPRESS_EN to advance on release instead and force OFF on a long hold.
module btn_led_ctrl
  import btn_led_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 250_000,
  parameter int SLOW_HALF    = 12_500_000,
  parameter int FAST_HALF    = 2_500_000
`ifdef BTN_LED_LONGPRESS_EN
  , parameter int LONG_CYC   = 100_000_000
`endif
) (
  input  logic       F_CLK,
  input  logic       F_RST,
  input  logic [1:1] F_KEY,
  output logic [2:1] F_LED,
  output logic [1:0] MODE
);

  localparam int BLINK_MAX = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
  localparam int BLINK_W   = $clog2(BLINK_MAX + 1);

  logic               press_s;
  logic               release_s;
  logic               advance;
  logic               long_hit;
  mode_e              mode_q;
  mode_e              mode_d;
  logic [BLINK_W-1:0] blink_cnt_q;
  logic [BLINK_W-1:0] blink_end;
  logic               phase_q;
  logic               held_q;
  logic               led_d3_q;

  key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk_i    (F_CLK),
    .rst_i    (F_RST),
    .key_i    (F_KEY[1]),
    .press_o  (press_s),
    .release_o(release_s)
  );

`ifdef BTN_LED_LONGPRESS_EN
  localparam int HOLD_W = $clog2(LONG_CYC + 1);

  logic [HOLD_W-1:0] hold_cnt_q;
  logic              long_q;

  assign long_hit = held_q && !long_q && (hold_cnt_q == HOLD_W'(LONG_CYC - 1));
  assign advance  = release_s && !long_q;

  // A release always ends a long hold; the flag only suppresses that one advance.
  always_ff @(posedge F_CLK or posedge F_RST) begin
    if (F_RST) begin
      hold_cnt_q <= '0;
      long_q     <= 1'b0;
    end else begin
      if (release_s) begin
        long_q <= 1'b0;
      end else if (long_hit) begin
        long_q <= 1'b1;
      end
      if (!held_q || long_q) begin
        hold_cnt_q <= '0;
      end else begin
        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
      end
    end
  end
`else
  assign long_hit = 1'b0;
  assign advance  = press_s;
`endif

  always_comb begin
    mode_d = mode_q;
    if (long_hit) begin
      mode_d = MODE_OFF;
    end else if (advance) begin
      mode_d = next_mode(mode_q);
    end
  end

  assign blink_end = (mode_q == MODE_SLOW) ? BLINK_W'(SLOW_HALF - 1) : BLINK_W'(FAST_HALF - 1);

  // Any mode change restarts the blink lit with a full half-period.
  always_ff @(posedge F_CLK or posedge F_RST) begin
    if (F_RST) begin
      mode_q      <= MODE_OFF;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      held_q      <= 1'b0;
      led_d3_q    <= 1'b0;
    end else begin
      mode_q <= mode_d;

      if (press_s) begin
        held_q <= 1'b1;
      end else if (release_s) begin
        held_q <= 1'b0;
      end

      if ((mode_d != mode_q) || (mode_q == MODE_OFF) || (mode_q == MODE_ON)) begin
        blink_cnt_q <= '0;
        phase_q     <= 1'b1;
      end else if (blink_cnt_q == blink_end) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
      end

      case (mode_q)
        MODE_OFF: led_d3_q <= 1'b0;
        MODE_ON:  led_d3_q <= 1'b1;
        default:  led_d3_q <= phase_q;
      endcase
    end
  end

  assign F_LED = {held_q, led_d3_q};
  assign MODE  = mode_q;

endmodule

// File: tb/tb_btn_led_ctrl.sv
// Directed table-driven bench for btn_led_ctrl with small timing parameters.
// Expected MODE/F_LED values are hand-derived per vector; BTN_LED_LONGPRESS_EN selects the table.
module tb_btn_led_ctrl;

  logic       F_CLK = 1'b0;
  logic       F_RST;
  logic [1:1] F_KEY;
  logic [2:1] F_LED;
  logic [1:0] MODE;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       key;
    int         cyc;
    logic [1:0] mode;
    logic [1:0] led;
  } vec_t;

  vec_t vq[$];

  btn_led_ctrl #(
    .DEBOUNCE_CYC(4),
    .SLOW_HALF   (8),
    .FAST_HALF   (2)
`ifdef BTN_LED_LONGPRESS_EN
    , .LONG_CYC  (20)
`endif
  ) dut (
    .F_CLK(F_CLK),
    .F_RST(F_RST),
    .F_KEY(F_KEY),
    .F_LED(F_LED),
    .MODE (MODE)
  );

  always #5 F_CLK = ~F_CLK;

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  function automatic void add(input logic k, input int c, input logic [1:0] m, input logic [1:0] l);
    vec_t v;
    v.key  = k;
    v.cyc  = c;
    v.mode = m;
    v.led  = l;
    vq.push_back(v);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge F_CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    F_RST    = 1'b1;
    F_KEY[1] = 1'b0;
    step(3);
    chk("reset MODE", MODE, 2'd0);
    chk("reset F_LED", F_LED, 2'b00);
    F_RST = 1'b0;

    // led column is {F_LED[2], F_LED[1]}
`ifndef BTN_LED_LONGPRESS_EN
    // key held through reset: press only after a full debounce window
    add(1'b0, 6, 2'd0, 2'b00);
    add(1'b0, 1, 2'd1, 2'b10);
    add(1'b0, 1, 2'd1, 2'b11);
    add(1'b1, 6, 2'd1, 2'b11);
    add(1'b1, 1, 2'd1, 2'b01);
    // 3-cycle glitch is ignored
    add(1'b0, 3, 2'd1, 2'b01);
    add(1'b1, 10, 2'd1, 2'b01);
    // press into SLOW, then 8 high / 8 low
    add(1'b0, 6, 2'd1, 2'b01);
    add(1'b0, 1, 2'd2, 2'b11);
    add(1'b1, 1, 2'd2, 2'b11);
    add(1'b1, 7, 2'd2, 2'b01);
    add(1'b1, 1, 2'd2, 2'b00);
    add(1'b1, 7, 2'd2, 2'b00);
    add(1'b1, 1, 2'd2, 2'b01);
    add(1'b1, 4, 2'd2, 2'b01);
    // press lands mid low phase: FAST restarts lit, 2 high / 2 low
    add(1'b0, 6, 2'd2, 2'b00);
    add(1'b0, 1, 2'd3, 2'b10);
    add(1'b0, 1, 2'd3, 2'b11);
    add(1'b0, 1, 2'd3, 2'b11);
    add(1'b0, 1, 2'd3, 2'b10);
    add(1'b0, 1, 2'd3, 2'b10);
    add(1'b0, 1, 2'd3, 2'b11);
    add(1'b1, 8, 2'd3, 2'b01);
    // wrap FAST -> OFF
    add(1'b0, 8, 2'd0, 2'b10);
    add(1'b1, 10, 2'd0, 2'b00);
    // bounce train before a press: exactly one step
    add(1'b0, 1, 2'd0, 2'b00);
    add(1'b1, 1, 2'd0, 2'b00);
    add(1'b0, 1, 2'd0, 2'b00);
    add(1'b1, 1, 2'd0, 2'b00);
    add(1'b0, 6, 2'd0, 2'b00);
    add(1'b0, 1, 2'd1, 2'b10);
    add(1'b0, 1, 2'd1, 2'b11);
    // bounce while held: no extra step
    add(1'b1, 1, 2'd1, 2'b11);
    add(1'b0, 1, 2'd1, 2'b11);
    add(1'b1, 1, 2'd1, 2'b11);
    add(1'b0, 10, 2'd1, 2'b11);
    add(1'b1, 10, 2'd1, 2'b01);
`else
    // key held through reset: advance only on the following release
    add(1'b0, 6, 2'd0, 2'b00);
    add(1'b0, 1, 2'd0, 2'b10);
    add(1'b0, 1, 2'd0, 2'b10);
    add(1'b1, 6, 2'd0, 2'b10);
    add(1'b1, 1, 2'd1, 2'b00);
    add(1'b1, 1, 2'd1, 2'b01);
    // short press to SLOW, advancing on release
    add(1'b0, 8, 2'd1, 2'b11);
    add(1'b1, 8, 2'd2, 2'b01);
    // long hold forces OFF; release leaves it OFF
    add(1'b0, 20, 2'd2, 2'b11);
    add(1'b0, 7, 2'd0, 2'b10);
    add(1'b0, 1, 2'd0, 2'b10);
    add(1'b1, 10, 2'd0, 2'b00);
    // short press: MODE changes on release, not on press
    add(1'b0, 10, 2'd0, 2'b10);
    add(1'b1, 10, 2'd1, 2'b01);
`endif

    foreach (vq[i]) begin
      F_KEY[1] = vq[i].key;
      step(vq[i].cyc);
      chk($sformatf("vec%0d MODE", i), MODE, vq[i].mode);
      chk($sformatf("vec%0d F_LED", i), F_LED, vq[i].led);
    end

    // reset asserted between clock edges must take effect without a clock
    #3;
    F_RST = 1'b1;
    #1;
    chk("async reset MODE", MODE, 2'd0);
    chk("async reset F_LED", F_LED, 2'b00);
    step(2);
    F_RST = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
